// File: rtl/multi_cycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the
// MIPS datapath it steers (slave).
interface multi_cycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_write;
  logic       mem_to_reg;
  logic       alu_src;
  logic       ext_op;
  logic [4:0] aluop;
  logic [2:0] state;
  logic       done;
  logic       illegal;

  modport master (
    input  op, funct, zero,
    output ir_write, pc_write, pc_src, reg_write, reg_dst, mem_write,
           mem_to_reg, alu_src, ext_op, aluop, state, done, illegal
  );

  modport slave (
    output op, funct, zero,
    input  ir_write, pc_write, pc_src, reg_write, reg_dst, mem_write,
           mem_to_reg, alu_src, ext_op, aluop, state, done, illegal
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset core: fetch, decode,
// execute, memory and write-back steps for ALU ops, lw, sw, beq and j.
module multi_cycle_ctrl (
  input  logic               reset,
  input  logic               clock,
  multi_cycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM_RD = 3'd3,
    MEM_WR = 3'd4,
    WB     = 3'd5,
    BRANCH = 3'd6,
    JUMP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_ALU  = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_J    = 3'd5
  } class_t;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_ADDU = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b00101;
  localparam logic [4:0] ALU_LUI  = 5'b01010;

  state_t     state_reg, state_next;
  class_t     cls_reg, cls_next;
  logic [4:0] aluop_reg, aluop_next;
  logic       ext_op_reg, ext_op_next;
  logic       alu_src_reg, alu_src_next;
  logic       reg_dst_reg, reg_dst_next;

  // Decode of the live IR fields; only consumed while in DECODE.
  always_comb begin
    cls_next     = CLS_NONE;
    aluop_next   = ALU_ADD;
    ext_op_next  = 1'b0;
    alu_src_next = 1'b0;
    reg_dst_next = 1'b0;
    case (bus.op)
      6'b000000: begin
        cls_next     = CLS_ALU;
        reg_dst_next = 1'b1;
        case (bus.funct)
          6'b100000: aluop_next = ALU_ADD;
          6'b100001: aluop_next = ALU_ADDU;
          6'b100011: aluop_next = ALU_SUB;
          6'b100100: aluop_next = ALU_AND;
          6'b100101: aluop_next = ALU_OR;
          6'b101010: aluop_next = ALU_SLT;
          default: begin
            cls_next     = CLS_NONE;
            reg_dst_next = 1'b0;
          end
        endcase
      end
      6'b001000: begin cls_next = CLS_ALU; aluop_next = ALU_ADD;  ext_op_next = 1'b1; alu_src_next = 1'b1; end
      6'b001001: begin cls_next = CLS_ALU; aluop_next = ALU_ADDU; ext_op_next = 1'b1; alu_src_next = 1'b1; end
      6'b001100: begin cls_next = CLS_ALU; aluop_next = ALU_AND;  alu_src_next = 1'b1; end
      6'b001101: begin cls_next = CLS_ALU; aluop_next = ALU_OR;   alu_src_next = 1'b1; end
      6'b001111: begin cls_next = CLS_ALU; aluop_next = ALU_LUI;  ext_op_next = 1'b1; alu_src_next = 1'b1; end
      6'b100011: begin cls_next = CLS_LW;  aluop_next = ALU_ADD;  ext_op_next = 1'b1; alu_src_next = 1'b1; end
      6'b101011: begin cls_next = CLS_SW;  aluop_next = ALU_ADD;  ext_op_next = 1'b1; alu_src_next = 1'b1; end
      6'b000100: begin cls_next = CLS_BEQ; aluop_next = ALU_SUB;  ext_op_next = 1'b1; end
      6'b000010: cls_next = CLS_J;
      default: ;
    endcase
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH: state_next = DECODE;
      DECODE: begin
        case (cls_next)
          CLS_ALU, CLS_LW, CLS_SW: state_next = EXEC;
          CLS_BEQ:                 state_next = BRANCH;
          CLS_J:                   state_next = JUMP;
          default:                 state_next = FETCH;
        endcase
      end
      EXEC: begin
        case (cls_reg)
          CLS_LW:  state_next = MEM_RD;
          CLS_SW:  state_next = MEM_WR;
          default: state_next = WB;
        endcase
      end
      MEM_RD:  state_next = WB;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= FETCH;
      cls_reg     <= CLS_NONE;
      aluop_reg   <= ALU_ADD;
      ext_op_reg  <= 1'b0;
      alu_src_reg <= 1'b0;
      reg_dst_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE) begin
        cls_reg     <= cls_next;
        aluop_reg   <= aluop_next;
        ext_op_reg  <= ext_op_next;
        alu_src_reg <= alu_src_next;
        reg_dst_reg <= reg_dst_next;
      end
    end
  end

  // Moore outputs, forced low while reset is held so an in-flight write
  // enable collapses before the next edge. The ALU controls stay driven
  // through MEM/WB because the datapath has no ALU output register.
  always_comb begin
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src    = 1'b0;
    bus.ext_op     = 1'b0;
    bus.aluop      = ALU_ADD;
    bus.done       = 1'b0;
    bus.illegal    = 1'b0;
    if (reset) begin
      case (state_reg)
        FETCH: begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
        end
        DECODE: bus.illegal = (cls_next == CLS_NONE);
        EXEC, MEM_RD, MEM_WR, WB, BRANCH: begin
          bus.aluop   = aluop_reg;
          bus.alu_src = alu_src_reg;
          bus.ext_op  = ext_op_reg;
          if (state_reg == MEM_WR) begin
            bus.mem_write = 1'b1;
            bus.done      = 1'b1;
          end
          if (state_reg == WB) begin
            bus.reg_write  = 1'b1;
            bus.reg_dst    = reg_dst_reg;
            bus.mem_to_reg = (cls_reg == CLS_LW);
            bus.done       = 1'b1;
          end
          if (state_reg == BRANCH) begin
            bus.pc_src   = 2'b01;
            bus.pc_write = bus.zero;
            bus.done     = 1'b1;
          end
        end
        JUMP: begin
          bus.pc_src   = 2'b10;
          bus.pc_write = 1'b1;
          bus.done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state = state_reg;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed instructions plus random
// instruction streams checked cycle by cycle against per-class expectations.
`timescale 1ns/1ps
module tb_multi_cycle_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  multi_cycle_ctrl_if bus ();
  multi_cycle_ctrl dut (.reset(reset), .clock(clock), .bus(bus));

  int checks = 0;
  int failures = 0;

  localparam logic [19:0] ALL   = 20'hFFFFF;
  localparam logic [19:0] NOEXT = 20'hFFF7F;

  logic [19:0] obs;
  assign obs = {bus.state, bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write,
                bus.reg_dst, bus.mem_write, bus.mem_to_reg, bus.alu_src,
                bus.ext_op, bus.aluop, bus.done, bus.illegal};

  function automatic logic [19:0] pk(input logic [2:0] st, input logic irw, input logic pcw,
                                     input logic [1:0] pcs, input logic rw, input logic rd,
                                     input logic mw, input logic m2r, input logic asrc,
                                     input logic ext, input logic [4:0] aop,
                                     input logic dn, input logic il);
    return {st, irw, pcw, pcs, rw, rd, mw, m2r, asrc, ext, aop, dn, il};
  endfunction

  // Instruction classes: 0 illegal, 1 ALU, 2 lw, 3 sw, 4 beq, 5 j.
  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] funct,
                                     output int kind, output logic [4:0] aop,
                                     output logic src, output logic ext, output logic dst);
    kind = 0; aop = 5'd0; src = 1'b0; ext = 1'b0; dst = 1'b0;
    if (op == 6'b000000) begin
      kind = 1; dst = 1'b1;
      case (funct)
        6'b100000: aop = 5'b00000;
        6'b100001: aop = 5'b00001;
        6'b100011: aop = 5'b00010;
        6'b100100: aop = 5'b00011;
        6'b100101: aop = 5'b00100;
        6'b101010: aop = 5'b00101;
        default: begin kind = 0; dst = 1'b0; end
      endcase
    end else begin
      case (op)
        6'b001000: begin kind = 1; aop = 5'b00000; ext = 1'b1; src = 1'b1; end
        6'b001001: begin kind = 1; aop = 5'b00001; ext = 1'b1; src = 1'b1; end
        6'b001100: begin kind = 1; aop = 5'b00011; ext = 1'b0; src = 1'b1; end
        6'b001101: begin kind = 1; aop = 5'b00100; ext = 1'b0; src = 1'b1; end
        6'b001111: begin kind = 1; aop = 5'b01010; ext = 1'b1; src = 1'b1; end
        6'b100011: begin kind = 2; aop = 5'b00000; ext = 1'b1; src = 1'b1; end
        6'b101011: begin kind = 3; aop = 5'b00000; ext = 1'b1; src = 1'b1; end
        6'b000100: begin kind = 4; aop = 5'b00010; end
        6'b000010: kind = 5;
        default: kind = 0;
      endcase
    end
  endfunction

  task automatic check(input string tag, input logic [19:0] exp_v, input logic [19:0] mask);
    checks++;
    assert ((obs & mask) === (exp_v & mask)) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs & mask, exp_v & mask);
    end
  endtask

  // Runs one instruction from FETCH; optionally asserts reset after cycle abort_at.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                           input logic z, input int abort_at);
    logic [19:0] ev[$];
    logic [19:0] em[$];
    int kind;
    logic [4:0] aop;
    logic src, ext, dst;
    bit aborted;
    aborted = 1'b0;
    ref_decode(op, funct, kind, aop, src, ext, dst);
    ev.push_back(pk(3'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    em.push_back(ALL);
    ev.push_back(pk(3'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, kind == 0));
    em.push_back(ALL);
    if (kind >= 1 && kind <= 3) begin
      ev.push_back(pk(3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, src, ext, aop, 1'b0, 1'b0));
      em.push_back(ALL);
    end
    if (kind == 1 || kind == 2) begin
      if (kind == 2) begin
        ev.push_back(pk(3'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, src, ext, aop, 1'b0, 1'b0));
        em.push_back(ALL);
      end
      ev.push_back(pk(3'd5, 1'b0, 1'b0, 2'b00, 1'b1, dst, 1'b0, kind == 2, src, ext, aop, 1'b1, 1'b0));
      em.push_back(ALL);
    end
    if (kind == 3) begin
      ev.push_back(pk(3'd4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, src, ext, aop, 1'b1, 1'b0));
      em.push_back(ALL);
    end
    if (kind == 4) begin
      ev.push_back(pk(3'd6, 1'b0, z, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b0));
      em.push_back(NOEXT);
    end
    if (kind == 5) begin
      ev.push_back(pk(3'd7, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0));
      em.push_back(ALL);
    end
    for (int i = 0; i < ev.size() && !aborted; i++) begin
      @(negedge clock);
      if (i == 1) begin
        bus.op = op; bus.funct = funct;
      end else begin
        bus.op = 6'($urandom); bus.funct = 6'($urandom);
      end
      bus.zero = (i >= 2) ? z : 1'($urandom);
      #1;
      check($sformatf("op=%b funct=%b z=%b cycle%0d", op, funct, z, i), ev[i], em[i]);
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        check("reset_abort", 20'h0, ALL);
        @(posedge clock);
        #1;
        check("reset_hold", 20'h0, ALL);
        #1 reset = 1'b1;
        aborted = 1'b1;
      end
    end
    $display("instr op=%b funct=%b zero=%b class=%0d cycles=%0d%s", op, funct, z, kind,
             ev.size(), aborted ? " (reset abort)" : "");
  endtask

  logic [5:0] legal_ops [0:9];

  initial begin
    legal_ops[0] = 6'b000000; legal_ops[1] = 6'b001000; legal_ops[2] = 6'b001001;
    legal_ops[3] = 6'b001100; legal_ops[4] = 6'b001101; legal_ops[5] = 6'b001111;
    legal_ops[6] = 6'b100011; legal_ops[7] = 6'b101011; legal_ops[8] = 6'b000100;
    legal_ops[9] = 6'b000010;
    bus.op = 6'b111111; bus.funct = 6'd0; bus.zero = 1'b1;

    #2;
    check("reset_state", 20'h0, ALL);
    repeat (2) @(posedge clock);
    #1;
    check("reset_held", 20'h0, ALL);
    @(posedge clock);
    #2 reset = 1'b1;

    run_instr(6'b001000, 6'b000101, 1'b0, -1);   // addi $1,$0,5
    run_instr(6'b000000, 6'b100011, 1'b0, -1);   // subu
    run_instr(6'b100011, 6'b000100, 1'b0, -1);   // lw
    run_instr(6'b101011, 6'b000100, 1'b0, -1);   // sw
    run_instr(6'b000100, 6'b000011, 1'b1, -1);   // beq taken
    run_instr(6'b000100, 6'b000011, 1'b0, -1);   // beq not taken
    run_instr(6'b000010, 6'b000000, 1'b0, -1);   // j 0x08000C00
    run_instr(6'b111111, 6'b000000, 1'b0, -1);   // illegal op
    run_instr(6'b000000, 6'b100010, 1'b0, -1);   // illegal funct
    run_instr(6'b001101, 6'b010101, 1'b0, 3);    // ori, reset during WB
    run_instr(6'b001111, 6'b000000, 1'b0, -1);   // lui after restart

    for (int n = 0; n < 250; n++) begin
      logic [5:0] op, funct;
      logic z;
      int abort_at;
      if ($urandom_range(0, 1) == 0) op = legal_ops[$urandom_range(0, 9)];
      else op = 6'($urandom);
      funct = 6'($urandom);
      if (op == 6'b000000 && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 5))
          0: funct = 6'b100000;
          1: funct = 6'b100001;
          2: funct = 6'b100011;
          3: funct = 6'b100100;
          4: funct = 6'b100101;
          default: funct = 6'b101010;
        endcase
      end
      z = 1'($urandom);
      abort_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(op, funct, z, abort_at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
